// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one 8-bit SDRAM controller port
// between loader (p0), CPU (p1) and video (p2). Each granted access is
// turned into a fixed window: strobe high SLOT clk, then low SLOT clk, so
// the slot-rate controller always sees one high and one low sample.
module sdram_arbiter #(
    parameter int SLOT      = 6,
    parameter int INIT_WAIT = 192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [24:0] p0_addr,
    input  logic [7:0]  p0_din,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [24:0] p1_addr,
    input  logic [7:0]  p1_din,
    output logic        p1_ack,
    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [24:0] p2_addr,
    input  logic [7:0]  p2_din,
    output logic        p2_ack,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_oe,
    output logic        mem_we,
    input  logic [7:0]  mem_dout
);

    localparam int IW = $clog2(INIT_WAIT + 1);
    localparam int CW = $clog2(2 * SLOT);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_ACK} state_t;

    state_t        state, state_next;
    logic [IW-1:0] init_cnt;
    logic [CW-1:0] cnt;
    logic [1:0]    rr;          // first port to look at on the next grant
    logic [1:0]    grant_idx;
    logic          we_l;
    logic [2:0]    acks;
    logic [2:0]    req;

    logic          sel_valid;
    logic [1:0]    sel;
    logic          sel_we;
    logic [24:0]   sel_addr;
    logic [7:0]    sel_din;
    logic          init_done;
    logic          access_last;
    logic          strobe_next;
    logic          we_next;
    logic          oe_out_next;
    logic          we_out_next;

    assign req         = {p2_req, p1_req, p0_req};
    assign init_done   = (init_cnt == IW'(INIT_WAIT - 1));
    assign access_last = (cnt == CW'(2 * SLOT - 1));
    assign p0_ack      = acks[0];
    assign p1_ack      = acks[1];
    assign p2_ack      = acks[2];

    // Round-robin pick: first requester at or after rr, wrapping 2 -> 0.
    always_comb begin
        int k;
        k         = 0;
        sel       = 2'd0;
        sel_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            k = int'(rr) + i;
            if (k >= 3) k = k - 3;
            if (!sel_valid && req[k]) begin
                sel       = 2'(k);
                sel_valid = 1'b1;
            end
        end
        case (sel)
            2'd1:    begin sel_we = p1_we; sel_addr = p1_addr; sel_din = p1_din; end
            2'd2:    begin sel_we = p2_we; sel_addr = p2_addr; sel_din = p2_din; end
            default: begin sel_we = p0_we; sel_addr = p0_addr; sel_din = p0_din; end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_INIT;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_INIT:   if (init_done) state_next = S_IDLE;
            S_IDLE:   if (sel_valid) state_next = S_ACCESS;
            S_ACCESS: if (access_last) state_next = S_ACK;
            default:  state_next = S_IDLE;
        endcase
    end

    // Strobe for the next cycle: high for cnt = 0..SLOT-1, so it is raised
    // on the grant edge and dropped when cnt moves past SLOT-1.
    always_comb begin
        strobe_next = 1'b0;
        we_next     = we_l;
        if (state == S_IDLE && sel_valid) begin
            strobe_next = 1'b1;
            we_next     = sel_we;
        end else if (state == S_ACCESS && cnt < CW'(SLOT - 1)) begin
            strobe_next = 1'b1;
        end
        oe_out_next = strobe_next & ~we_next;
        we_out_next = strobe_next & we_next;
    end

    // Registered outputs, counters, grant latch and read capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt  <= '0;
            cnt       <= '0;
            rr        <= 2'd0;
            grant_idx <= 2'd0;
            we_l      <= 1'b0;
            acks      <= 3'b000;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
        end else begin
            mem_oe <= oe_out_next;
            mem_we <= we_out_next;
            acks   <= 3'b000;
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_done) ready <= 1'b1;
                end
                S_IDLE: begin
                    if (sel_valid) begin
                        mem_addr  <= sel_addr;
                        mem_din   <= sel_din;
                        we_l      <= sel_we;
                        grant_idx <= sel;
                        rr        <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                        cnt       <= '0;
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (access_last) begin
                        if (!we_l) rdata <= mem_dout;
                        acks <= 3'b001 << grant_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
